avalon_pio_ctrl: RTL and testbench

- Parametrised Avalon-MM slave general-purpose I/O block; next generation of the single-bit output-register PIO (USB reset line, LEDs, keys).
- Provides a DATA_W-bit output register with atomic set/clear and a hardware-timed auto-clearing pulse, so a USB reset needs no software delay loop.
- Provides a synchronised DATA_W-bit input port with edge capture and a maskable interrupt.
- Sits on the lab62soc system interconnect; one instance per peripheral group.

---
 rtl/pio_pkg.sv | 29 ++
 rtl/pio_edge_sync.sv | 56 +++++
 rtl/avalon_pio_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_avalon_pio_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared definitions for the avalon_pio_ctrl general-purpose I/O block:
//   - word addresses of the register map (ADDR_DATA .. ADDR_PULSE)
//   - edge-capture sense selectors (EDGE_RISE / EDGE_FALL / EDGE_ANY)
//   - pulse timer state type (P_IDLE / P_ACTIVE)
// No ports (package).
// -----------------------------------------------------------------------------
package pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_IN        = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd6;
  localparam logic [2:0] ADDR_PULSE     = 3'd7;

  localparam int EDGE_RISE = 32'sd0;
  localparam int EDGE_FALL = 32'sd1;
  localparam int EDGE_ANY  = 32'sd2;

  typedef enum logic [0:0] {
    P_IDLE   = 1'b0,
    P_ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/pio_edge_sync.sv
// -----------------------------------------------------------------------------
// pio_edge_sync
// Two-flop synchroniser for asynchronous inputs, followed by a one-cycle delay
// flop and an edge detector whose sense is chosen by EDGE_TYPE.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   din      in   DATA_W asynchronous inputs
//   sync     out  DATA_W synchronised inputs (second synchroniser stage)
//   edges    out  DATA_W one-cycle edge strobes (combinational from flops)
// -----------------------------------------------------------------------------
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sync,
  output logic [DATA_W-1:0] edges
);

  logic [DATA_W-1:0] meta_r;
  logic [DATA_W-1:0] sync_r;
  logic [DATA_W-1:0] dly_r;
  logic [DATA_W-1:0] edges_s;

  // synchroniser chain plus delayed copy used for edge comparison
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_r <= {DATA_W{1'b0}};
      sync_r <= {DATA_W{1'b0}};
      dly_r  <= {DATA_W{1'b0}};
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      dly_r  <= sync_r;
    end
  end

  // edge detect on synchronised value against its one-cycle-old copy
  always_comb begin
    edges_s = {DATA_W{1'b0}};
    case (EDGE_TYPE)
      EDGE_FALL: edges_s = ~sync_r & dly_r;
      EDGE_ANY:  edges_s = sync_r ^ dly_r;
      default:   edges_s = sync_r & ~dly_r;
    endcase
  end

  assign sync  = sync_r;
  assign edges = edges_s;

endmodule

// File: rtl/avalon_pio_ctrl.sv
// -----------------------------------------------------------------------------
// avalon_pio_ctrl
// Avalon-MM slave GPIO: DATA_W-bit output register with atomic set/clear and an
// optional hardware-timed auto-clearing pulse, plus a synchronised input port
// with edge capture and a maskable level interrupt.
// Optional feature macro: PIO_PULSE_EN (pulse timer, addresses 6/7). When it is
// not defined, addresses 6/7 read 0 and ignore writes.
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   address     in   3-bit word address
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   32-bit write data (bits above DATA_W ignored)
//   readdata    out  32-bit zero-extended read data, combinational
//   in_port     in   DATA_W asynchronous inputs
//   out_port    out  DATA_W registered outputs
//   irq         out  registered level interrupt
// -----------------------------------------------------------------------------
module avalon_pio_ctrl
  import pio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 16,
  parameter int                EDGE_TYPE = EDGE_RISE,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic              wr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] sync_s;
  logic [DATA_W-1:0] edge_s;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_nxt_s;
  logic [DATA_W-1:0] irqmask_r;
  logic [DATA_W-1:0] edgecap_r;
  logic [DATA_W-1:0] edgecap_nxt_s;
  logic              irq_r;
  logic              unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign wdata_s  = writedata[DATA_W-1:0];
  assign unused_s = ^writedata;

  pio_edge_sync #(
    .DATA_W   (DATA_W),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_edge_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (in_port),
    .sync   (sync_s),
    .edges  (edge_s)
  );

`ifdef PIO_PULSE_EN
  pulse_state_t      state_r;
  pulse_state_t      state_nxt_s;
  logic [CNT_W-1:0]  pulse_len_r;
  logic [CNT_W-1:0]  pulse_cnt_r;
  logic [DATA_W-1:0] pulse_mask_r;
  logic              trig_s;
  logic              expire_s;
  logic              busy_s;

  // a PULSE write with an all-zero mask is not a trigger
  assign trig_s = wr_s && (address == ADDR_PULSE) && (wdata_s != {DATA_W{1'b0}});

  // pulse FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= P_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // pulse FSM next-state logic; a retrigger always keeps the timer running
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      P_IDLE: begin
        if (trig_s) state_nxt_s = P_ACTIVE;
        else        state_nxt_s = P_IDLE;
      end
      P_ACTIVE: begin
        if (trig_s)                            state_nxt_s = P_ACTIVE;
        else if (pulse_cnt_r == CNT_W'(1))     state_nxt_s = P_IDLE;
        else                                   state_nxt_s = P_ACTIVE;
      end
      default: state_nxt_s = P_IDLE;
    endcase
  end

  // pulse FSM outputs: busy flag and the expiry strobe that clears out_reg bits
  always_comb begin
    busy_s   = 1'b0;
    expire_s = 1'b0;
    case (state_r)
      P_ACTIVE: begin
        busy_s   = 1'b1;
        expire_s = (pulse_cnt_r == CNT_W'(1)) && !trig_s;
      end
      default: begin
        busy_s   = 1'b0;
        expire_s = 1'b0;
      end
    endcase
  end

  // pulse length, down-counter and mask of bits owned by the running pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pulse_len_r  <= CNT_W'(1);
      pulse_cnt_r  <= {CNT_W{1'b0}};
      pulse_mask_r <= {DATA_W{1'b0}};
    end else begin
      if (wr_s && (address == ADDR_PULSE_LEN)) begin
        // a zero length would never expire, so it is stored as 1
        if (writedata[CNT_W-1:0] == {CNT_W{1'b0}}) pulse_len_r <= CNT_W'(1);
        else                                       pulse_len_r <= writedata[CNT_W-1:0];
      end
      if (trig_s) begin
        pulse_mask_r <= pulse_mask_r | wdata_s;
        pulse_cnt_r  <= pulse_len_r;
      end else if (expire_s) begin
        pulse_mask_r <= {DATA_W{1'b0}};
        pulse_cnt_r  <= {CNT_W{1'b0}};
      end else if (busy_s) begin
        pulse_cnt_r  <= pulse_cnt_r - CNT_W'(1);
      end
    end
  end
`endif

  // out_reg next value: pulse expiry first, any bus write on top of it
  always_comb begin
    out_nxt_s = out_r;
`ifdef PIO_PULSE_EN
    if (expire_s) out_nxt_s = out_r & ~pulse_mask_r;
    else          out_nxt_s = out_r;
`endif
    if (wr_s) begin
      case (address)
        ADDR_DATA:   out_nxt_s = wdata_s;
        ADDR_OUTSET: out_nxt_s = out_nxt_s | wdata_s;
        ADDR_OUTCLR: out_nxt_s = out_nxt_s & ~wdata_s;
`ifdef PIO_PULSE_EN
        ADDR_PULSE:  out_nxt_s = out_nxt_s | wdata_s;
`endif
        default:     out_nxt_s = out_nxt_s;
      endcase
    end else begin
      out_nxt_s = out_nxt_s;
    end
  end

  // edge capture: a new edge wins over a same-cycle write-1-to-clear
  always_comb begin
    edgecap_nxt_s = edgecap_r;
    if (wr_s && (address == ADDR_EDGECAP)) edgecap_nxt_s = (edgecap_r & ~wdata_s) | edge_s;
    else                                   edgecap_nxt_s = edgecap_r | edge_s;
  end

  // output, mask, capture and interrupt registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_r     <= RESET_VAL;
      irqmask_r <= {DATA_W{1'b0}};
      edgecap_r <= {DATA_W{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      if (wr_s && (address == ADDR_IRQMASK)) irqmask_r <= wdata_s;
      edgecap_r <= edgecap_nxt_s;
      irq_r     <= |(edgecap_r & irqmask_r);
    end
  end

  // zero-wait combinational read mux
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DATA:      readdata = 32'(out_r);
      ADDR_IN:        readdata = 32'(sync_s);
      ADDR_IRQMASK:   readdata = 32'(irqmask_r);
      ADDR_EDGECAP:   readdata = 32'(edgecap_r);
`ifdef PIO_PULSE_EN
      ADDR_PULSE_LEN: readdata = 32'(pulse_len_r);
      ADDR_PULSE: begin
        readdata     = 32'(pulse_mask_r);
        readdata[31] = busy_s;
      end
`endif
      default:        readdata = 32'h0000_0000;
    endcase
  end

  assign out_port = out_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_avalon_pio_ctrl
// Self-checking bench for avalon_pio_ctrl (DATA_W=8, CNT_W=16, rising edges,
// RESET_VAL=8'h01). Follows PIO_PULSE_EN to pick the expected pulse behaviour.
// -----------------------------------------------------------------------------
module tb_avalon_pio_ctrl;

  localparam logic [7:0] RV = 8'h01;
`ifdef PIO_PULSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  avalon_pio_ctrl #(
    .DATA_W(8), .CNT_W(16), .EDGE_TYPE(0), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  typedef struct {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  // behavioural model state
  logic [7:0]  m_out, m_mask, m_cap, m_pmask;
  logic        m_irq;
  logic [15:0] m_plen;
  int          cyc, m_deadline;
  logic [7:0]  hist[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_out};
      3'd1:    return {24'h0, hist[1]};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap};
      3'd6:    return PEN ? {16'h0, m_plen} : 32'h0;
      3'd7:    return PEN ? {(m_pmask != 8'h00), 23'h0, m_pmask} : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_out = RV; m_mask = 8'h00; m_cap = 8'h00; m_pmask = 8'h00; m_irq = 1'b0;
    m_plen = 16'd1; m_deadline = -1; cyc = 0;
    for (int i = 0; i < 4; i++) hist[i] = 8'h00;
  endtask

  // one rising edge of the reference: hist[k] is in_port sampled k edges ago
  task automatic m_step(input logic w, input logic [2:0] a, input logic [31:0] d, input logic [7:0] inp);
    logic [7:0] wd, ed;
    logic nirq, trig;
    wd = d[7:0];
    cyc++;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = inp;
    ed   = hist[2] & ~hist[3];
    nirq = |(m_cap & m_mask);
    trig = PEN && w && (a == 3'd7) && (wd != 8'h00);
    if (!trig && (m_pmask != 8'h00) && (cyc == m_deadline)) begin
      m_out = m_out & ~m_pmask;
      m_pmask = 8'h00;
    end
    if (w) begin
      case (a)
        3'd0: m_out = wd;
        3'd2: m_mask = wd;
        3'd3: m_cap = m_cap & ~wd;
        3'd4: m_out = m_out | wd;
        3'd5: m_out = m_out & ~wd;
        3'd6: if (PEN) m_plen = (d[15:0] == 16'h0) ? 16'd1 : d[15:0];
        3'd7: if (trig) begin
          m_out = m_out | wd; m_pmask = m_pmask | wd; m_deadline = cyc + int'(m_plen);
        end
        default: ;
      endcase
    end
    m_cap = m_cap | ed;
    m_irq = nirq;
  endtask

  initial begin
    int high_cnt, first_low;

    // ---- reset held two cycles ----
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("reset_out", 32'(out_port), 32'h01);
    chk("reset_irq", 32'(irq), 32'h0);
    rd_chk("reset_plen", 3'd6, PEN ? 32'd1 : 32'd0);

    // ---- table of single-cycle register operations ----
    vecs[0]  = '{3'd0, 32'h0000_00F0, 8'hF0, 3'd0, 32'h0000_00F0};
    vecs[1]  = '{3'd4, 32'h0000_0005, 8'hF5, 3'd4, 32'h0};
    vecs[2]  = '{3'd5, 32'h0000_0030, 8'hC5, 3'd5, 32'h0};
    vecs[3]  = '{3'd2, 32'h0000_0004, 8'hC5, 3'd2, 32'h0000_0004};
    vecs[4]  = '{3'd0, 32'h1234_56AA, 8'hAA, 3'd0, 32'h0000_00AA};
    vecs[5]  = '{3'd1, 32'h0000_0055, 8'hAA, 3'd1, 32'h0};
    vecs[6]  = '{3'd5, 32'h0000_00FF, 8'h00, 3'd0, 32'h0};
    vecs[7]  = '{3'd6, 32'h0000_0000, 8'h00, 3'd6, PEN ? 32'd1 : 32'd0};
    vecs[8]  = '{3'd6, 32'h0000_0003, 8'h00, 3'd6, PEN ? 32'd3 : 32'd0};
    vecs[9]  = '{3'd6, 32'h0001_000A, 8'h00, 3'd6, PEN ? 32'd10 : 32'd0};
    vecs[10] = '{3'd4, 32'hFFFF_FF00, 8'h00, 3'd3, 32'h0};
    for (int i = 0; i < 11; i++) begin
      chipselect = 1'b1; write_n = 1'b0; address = vecs[i].waddr; writedata = vecs[i].wdata;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
    end

`ifdef PIO_PULSE_EN
    // ---- single pulse of 10 cycles ----
    wr(3'd7, 32'h01);
    high_cnt = 0; first_low = -1;
    for (int i = 0; i < 20; i++) begin
      if (out_port[0]) high_cnt++;
      else if (first_low < 0) first_low = i;
      if (i == 5) rd_chk("pulse_busy", 3'd7, 32'h8000_0001);
      tick();
    end
    chk("pulse_high_cycles", 32'(high_cnt), 32'd10);
    chk("pulse_first_low", 32'(first_low), 32'd10);
    chk("pulse_after_out", 32'(out_port), 32'h00);
    rd_chk("pulse_after_busy", 3'd7, 32'h0);

    // ---- retrigger: both bits expire 10 cycles after the second write ----
    wr(3'd7, 32'h01);
    tick(); tick(); tick();
    wr(3'd7, 32'h02);
    for (int i = 0; i < 9; i++) tick();
    chk("retrig_still_high", 32'(out_port), 32'h03);
    rd_chk("retrig_mask", 3'd7, 32'h8000_0003);
    tick();
    chk("retrig_cleared", 32'(out_port), 32'h00);

    // ---- reset mid-pulse aborts ----
    wr(3'd7, 32'h02);
    chk("abort_pre", 32'(out_port), 32'h02);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_out", 32'(out_port), 32'(RV));
    rd_chk("abort_busy", 3'd7, 32'h0);
    rd_chk("abort_plen", 3'd6, 32'd1);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_out_later", 32'(out_port), 32'(RV));
`else
    // ---- pulse feature absent: addresses 6/7 inert ----
    wr(3'd0, 32'h3C);
    wr(3'd7, 32'hFF);
    chk("nopulse_out", 32'(out_port), 32'h3C);
    tick(); tick();
    chk("nopulse_out_later", 32'(out_port), 32'h3C);
    rd_chk("nopulse_rd6", 3'd6, 32'h0);
    rd_chk("nopulse_rd7", 3'd7, 32'h0);
`endif

    // ---- edge capture and interrupt ----
    wr(3'd2, 32'h04);
    in_port = 8'h04;
    tick(); rd_chk("edge_lat1", 3'd3, 32'h0);
    tick(); rd_chk("edge_lat2", 3'd3, 32'h0);
    tick(); rd_chk("edge_lat3", 3'd3, 32'h04);
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    wr(3'd3, 32'h04);
    rd_chk("w1c_cleared", 3'd3, 32'h0);
    tick();
    chk("irq_dropped", 32'(irq), 32'h0);

    // falling edge must not capture, then W1C coincident with a new rise
    in_port = 8'h00;
    tick(); tick(); tick(); tick();
    rd_chk("fall_ignored", 3'd3, 32'h0);
    in_port = 8'h04;
    tick(); tick();
    wr(3'd3, 32'h04);
    rd_chk("w1c_vs_edge", 3'd3, 32'h04);
    tick();
    chk("w1c_vs_edge_irq", 32'(irq), 32'h1);

    // ---- randomized traffic against the reference model ----
    in_port = 8'h00;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_reset();
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd6) d = 32'($urandom_range(0, 6));
      if (a == 3'd7 && $urandom_range(0, 3) == 0) d = 32'h0;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = a;
      writedata  = d;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      #1;
      chk("rnd_readdata", readdata, m_read(a));
      chk("rnd_out", 32'(out_port), 32'(m_out));
      chk("rnd_irq", 32'(irq), 32'(m_irq));
      @(posedge clk);
      m_step(chipselect & ~write_n, a, d, in_port);
      #1;
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
